// File: rtl/weight_feeder.sv
// weight_feeder: read sequencer and diagonal skew stage between the 4-row
// weight RAM and the west/north edge of the systolic array.
// Optional build macro: FEEDER_BASE_EN (latch base_addr on start; otherwise
// the tile base is fixed at 0 and base_addr is ignored).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; outputs quiet
// READ   | oe=1, one RAM address per cycle, DEPTH cycles
// DRAIN  | oe=0, skew registers flush the last words, ROWS-1 cycles
// DONE   | done pulse for one cycle, then back to IDLE
module weight_feeder #(
  parameter int DATA_W = 16,
  parameter int ROWS   = 4,
  parameter int DEPTH  = 5,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] addr_out,
  output logic              oe,
  input  logic [DATA_W-1:0] q0,
  input  logic [DATA_W-1:0] q1,
  input  logic [DATA_W-1:0] q2,
  input  logic [DATA_W-1:0] q3,
  output logic [DATA_W-1:0] w0,
  output logic [DATA_W-1:0] w1,
  output logic [DATA_W-1:0] w2,
  output logic [DATA_W-1:0] w3,
  output logic [ROWS-1:0]   w_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DRN_W = (ROWS > 2) ? $clog2(ROWS - 1) : 1;
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(DEPTH - 1);
  // Drain is a down-counter: loaded with ROWS-2, exits when it reads zero.
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(ROWS - 2);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  col_q, col_d;
  logic [DRN_W-1:0]  drn_q, drn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              oe_q, oe_d;
  logic [ADDR_W-1:0] base_now;

`ifdef FEEDER_BASE_EN
  logic [ADDR_W-1:0] base_q;

  // Hold the tile base captured on the start edge for the whole tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      base_q <= base_addr;
    end
  end

  assign base_now = (state_q == S_IDLE) ? base_addr : base_q;
`else
  logic unused_base;
  assign unused_base = ^base_addr;
  assign base_now    = '0;
`endif

  // Next-state logic for the sequencer and its registered RAM controls.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    drn_d   = drn_q;
    addr_d  = addr_q;
    oe_d    = oe_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          col_d   = '0;
          addr_d  = base_now;
          oe_d    = 1'b1;
        end
      end
      S_READ: begin
        if (col_q == COL_LAST) begin
          state_d = S_DRAIN;
          col_d   = '0;
          addr_d  = '0;
          oe_d    = 1'b0;
          drn_d   = DRN_LOAD;
        end else begin
          col_d  = col_q + 1'b1;
          addr_d = base_now + ADDR_W'(col_d);
        end
      end
      S_DRAIN: begin
        if (drn_q == '0) begin
          state_d = S_DONE;
        end else begin
          drn_d = drn_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state, counters and RAM address/enable registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      drn_q   <= '0;
      addr_q  <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      drn_q   <= drn_d;
      addr_q  <= addr_d;
      oe_q    <= oe_d;
    end
  end

  // RAM data is only meaningful while oe is high; zeros are captured otherwise
  // so the skewed outputs read 0 whenever their valid bit is low.
  logic [DATA_W-1:0] cap0, cap1, cap2, cap3;
  assign cap0 = oe_q ? q0 : '0;
  assign cap1 = oe_q ? q1 : '0;
  assign cap2 = oe_q ? q2 : '0;
  assign cap3 = oe_q ? q3 : '0;

  logic [DATA_W-1:0]        r0_q;
  logic [1:0][DATA_W-1:0]   r1_q;
  logic [2:0][DATA_W-1:0]   r2_q;
  logic [3:0][DATA_W-1:0]   r3_q;
  logic [ROWS-1:0]          vld_q;

  // Row r passes through r+1 registers, producing the diagonal wavefront.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_q  <= '0;
      r1_q  <= '0;
      r2_q  <= '0;
      r3_q  <= '0;
      vld_q <= '0;
    end else begin
      r0_q  <= cap0;
      r1_q  <= {r1_q[0], cap1};
      r2_q  <= {r2_q[1:0], cap2};
      r3_q  <= {r3_q[2:0], cap3};
      vld_q <= {vld_q[ROWS-2:0], oe_q};
    end
  end

  assign addr_out = addr_q;
  assign oe       = oe_q;
  assign w0       = r0_q;
  assign w1       = r1_q[1];
  assign w2       = r2_q[2];
  assign w3       = r3_q[3];
  assign w_valid  = vld_q;
  assign busy     = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_weight_feeder.sv
// Self-checking bench for weight_feeder: a RAM model on q0..q3, expected
// per-cycle records queued at stimulus time and popped every cycle.
module tb_weight_feeder;
  localparam int DATA_W = 16;
  localparam int ROWS   = 4;
  localparam int DEPTH  = 5;
  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] addr_out;
  logic              oe;
  logic [DATA_W-1:0] q0, q1, q2, q3;
  logic [DATA_W-1:0] w0, w1, w2, w3;
  logic [ROWS-1:0]   w_valid;
  logic              busy, done;

  weight_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .addr_out(addr_out), .oe(oe),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3),
    .w_valid(w_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                tag;
    int                t;
    logic [ADDR_W-1:0] addr;
    logic              oe;
    logic [DATA_W-1:0] w0, w1, w2, w3;
    logic [ROWS-1:0]   vld;
    logic              busy;
    logic              done;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  // 20-word RAM, row stride 5: word(r*5+c) = 0x00rc for c<4, 0 for c=4.
  function automatic logic [DATA_W-1:0] ram_word(int r, logic [ADDR_W-1:0] a);
    int idx;
    idx = r * 5 + int'(a);
    if (idx >= 20) return '0;
    if (idx % 5 == 4) return '0;
    return DATA_W'((idx / 5) * 16 + idx % 5);
  endfunction

  // Garbage on q while oe is low: the DUT must not capture it.
  always_comb begin
    q0 = oe ? ram_word(0, addr_out) : 16'hdea0;
    q1 = oe ? ram_word(1, addr_out) : 16'hdea1;
    q2 = oe ? ram_word(2, addr_out) : 16'hdea2;
    q3 = oe ? ram_word(3, addr_out) : 16'hdea3;
  end

  function automatic exp_t mk(int t, logic [ADDR_W-1:0] a, logic o,
                              logic [DATA_W-1:0] x0, logic [DATA_W-1:0] x1,
                              logic [DATA_W-1:0] x2, logic [DATA_W-1:0] x3,
                              logic [ROWS-1:0] v, logic b, logic d);
    exp_t e;
    e.tag = 1; e.t = t; e.addr = a; e.oe = o;
    e.w0 = x0; e.w1 = x1; e.w2 = x2; e.w3 = x3;
    e.vld = v; e.busy = b; e.done = d;
    return e;
  endfunction

  // Expected outputs during cycle Tt of a tile started at T0 (t=0: idle).
  function automatic exp_t exp_rec(int tag, int t, logic [ADDR_W-1:0] base);
    exp_t e;
    logic [DATA_W-1:0] w[4];
    int k;
    e.tag  = tag;
    e.t    = t;
    e.oe   = (t >= 1 && t <= DEPTH);
    e.addr = e.oe ? ADDR_W'(int'(base) + t - 1) : '0;
    e.vld  = '0;
    for (int r = 0; r < ROWS; r++) begin
      k    = t - 2 - r;
      w[r] = '0;
      if (k >= 0 && k < DEPTH) begin
        e.vld[r] = 1'b1;
        w[r]     = ram_word(r, ADDR_W'(int'(base) + k));
      end
    end
    e.w0 = w[0]; e.w1 = w[1]; e.w2 = w[2]; e.w3 = w[3];
    e.busy = (t >= 1 && t <= DEPTH + ROWS - 1);
    e.done = (t == DEPTH + ROWS);
    return e;
  endfunction

  task automatic chk(string nm, exp_t e, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s tag%0d T%0d: got %0h expected %0h", nm, e.tag, e.t, act, req);
  endtask

  task automatic cmp(exp_t e);
    chk("addr_out", e, 32'(addr_out), 32'(e.addr));
    chk("oe",       e, 32'(oe),       32'(e.oe));
    chk("w0",       e, 32'(w0),       32'(e.w0));
    chk("w1",       e, 32'(w1),       32'(e.w1));
    chk("w2",       e, 32'(w2),       32'(e.w2));
    chk("w3",       e, 32'(w3),       32'(e.w3));
    chk("w_valid",  e, 32'(w_valid),  32'(e.vld));
    chk("busy",     e, 32'(busy),     32'(e.busy));
    chk("done",     e, 32'(done),     32'(e.done));
  endtask

  // Advance one cycle and compare mid-cycle against the next queued record.
  task automatic step();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      total++;
      $display("FAIL scoreboard_empty: got busy=%b expected a queued record", busy);
    end else begin
      e = sb.pop_front();
      cmp(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t tbl[10];
    logic [ADDR_W-1:0] bexp;

    tbl[0] = mk(1,  7'd0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 1'b1, 1'b0);
    tbl[1] = mk(2,  7'd1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 1'b1, 1'b0);
    tbl[2] = mk(3,  7'd2, 1'b1, 16'h0001, 16'h0010, 16'h0000, 16'h0000, 4'b0011, 1'b1, 1'b0);
    tbl[3] = mk(4,  7'd3, 1'b1, 16'h0002, 16'h0011, 16'h0020, 16'h0000, 4'b0111, 1'b1, 1'b0);
    tbl[4] = mk(5,  7'd4, 1'b1, 16'h0003, 16'h0012, 16'h0021, 16'h0030, 4'b1111, 1'b1, 1'b0);
    tbl[5] = mk(6,  7'd0, 1'b0, 16'h0000, 16'h0013, 16'h0022, 16'h0031, 4'b1111, 1'b1, 1'b0);
    tbl[6] = mk(7,  7'd0, 1'b0, 16'h0000, 16'h0000, 16'h0023, 16'h0032, 4'b1110, 1'b1, 1'b0);
    tbl[7] = mk(8,  7'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0033, 4'b1100, 1'b1, 1'b0);
    tbl[8] = mk(9,  7'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b1000, 1'b0, 1'b1);
    tbl[9] = mk(10, 7'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 1'b0, 1'b0);

    // Reset, then 10 quiet cycles with start low.
    for (int i = 0; i < 2; i++) begin sb.push_back(exp_rec(0, 0, '0)); step(); end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin sb.push_back(exp_rec(0, 0, '0)); step(); end

    // Basic tile and skew check from the literal table.
    for (int i = 0; i < 10; i++) sb.push_back(tbl[i]);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 9; i++) step();

    // start at T3 and T9 ignored; start at T10 gives a new tile from T11.
    for (int t = 1; t <= 10; t++) sb.push_back(exp_rec(2, t, '0));
    for (int t = 1; t <= 10; t++) sb.push_back(exp_rec(3, t, '0));
    for (int k = 0; k < 20; k++) begin
      start = (k == 0 || k == 3 || k == 9 || k == 10);
      step();
    end
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin sb.push_back(exp_rec(0, 0, '0)); step(); end

    // Reset mid-tile: asynchronous clear, nothing until a new start.
    for (int t = 1; t <= 4; t++) sb.push_back(exp_rec(4, t, '0));
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b0;
    #1;
    cmp(exp_rec(5, 0, '0));
    sb.push_back(exp_rec(5, 0, '0)); step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin sb.push_back(exp_rec(6, 0, '0)); step(); end
    for (int t = 1; t <= 10; t++) sb.push_back(exp_rec(7, t, '0));
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 9; i++) step();

    // Base address: latched at T0 when enabled, later changes ignored.
`ifdef FEEDER_BASE_EN
    bexp = 7'd2;
`else
    bexp = 7'd0;
`endif
    for (int t = 1; t <= 10; t++) sb.push_back(exp_rec(8, t, bexp));
    base_addr = 7'd2; start = 1'b1; step(); start = 1'b0;
    base_addr = 7'd7;
    for (int i = 0; i < 9; i++) step();
    base_addr = 7'd0;

    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_leftover: got %0d records expected 0", sb.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
